// File: rtl/hsv_core_ctrlstatus_cpuif_arbiter_pkg.sv
// Shared types for the ctrlstatus CPU-interface arbiter: FSM state and the latched request.
package hsv_core_ctrlstatus_cpuif_arbiter_pkg;
  localparam int CSR_ADDR_W = 16;
  localparam int CSR_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} cpuif_arb_state_t;

  typedef struct packed {
    logic                  is_wr;
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_DATA_W-1:0] wr_data;
    logic [CSR_DATA_W-1:0] biten;
  } cpuif_req_t;
endpackage

// File: rtl/hsv_core_rr_arbiter.sv
// Combinational round-robin pick: first eligible index strictly after last_grant, wrapping.
module hsv_core_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] idx;

  // Walk from farthest to nearest so the nearest eligible index is the last one written.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end
endmodule

// File: rtl/hsv_core_ctrlstatus_cpuif_arbiter.sv
// Shares the ctrlstatus regs CPU interface between NUM_REQ requesters, one transaction in flight,
// round-robin grant, ack routed back to the owner, forced error completion on timeout.
module hsv_core_ctrlstatus_cpuif_arbiter
  import hsv_core_ctrlstatus_cpuif_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk_core,
  input  logic                       rst_core,
  input  logic                       flush_req,
  input  logic [NUM_REQ-1:0]         m_req,
  input  logic [NUM_REQ-1:0]         m_req_is_wr,
  input  logic [NUM_REQ*16-1:0]      m_addr,
  input  logic [NUM_REQ*32-1:0]      m_wr_data,
  input  logic [NUM_REQ*32-1:0]      m_wr_biten,
  output logic [NUM_REQ-1:0]         m_accept,
  output logic [NUM_REQ-1:0]         m_ack,
  output logic                       m_err,
  output logic [31:0]                m_rd_data,
  output logic                       regs_req,
  output logic                       regs_req_is_wr,
  output logic [15:0]                regs_addr,
  output logic [31:0]                regs_wr_data,
  output logic [31:0]                regs_wr_biten,
  input  logic                       regs_req_stall_wr,
  input  logic                       regs_req_stall_rd,
  input  logic                       regs_rd_ack,
  input  logic                       regs_rd_err,
  input  logic                       regs_wr_ack,
  input  logic                       regs_wr_err,
  input  logic [31:0]                regs_rd_data,
  output logic                       busy
);
  localparam int IDX_W = $clog2(NUM_REQ);

  cpuif_arb_state_t   state, state_nxt;
  logic [IDX_W-1:0]   last_grant, owner, grant_idx;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_valid, grant;
  cpuif_req_t         req_sel, req_q;
  logic [15:0]        tmo_cnt;
  logic               stall, ack_match, err_match, timeout;
  logic               complete, tmo_err, cpl_err;

  always_comb begin
    eligible    = m_req;
    eligible[0] = m_req[0] & ~flush_req;
  end

  hsv_core_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible    (eligible),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign grant = (state == IDLE) && grant_valid;

  // Accept is combinational so the requester sees it in the cycle its request wins.
  always_comb begin
    m_accept = '0;
    if (grant && !rst_core) m_accept[grant_idx] = 1'b1;
  end

  always_comb begin
    req_sel.is_wr   = m_req_is_wr[grant_idx];
    req_sel.addr    = m_addr[int'(grant_idx)*CSR_ADDR_W +: CSR_ADDR_W];
    req_sel.wr_data = m_wr_data[int'(grant_idx)*CSR_DATA_W +: CSR_DATA_W];
    req_sel.biten   = m_wr_biten[int'(grant_idx)*CSR_DATA_W +: CSR_DATA_W];
  end

  assign stall     = req_q.is_wr ? regs_req_stall_wr : regs_req_stall_rd;
  assign ack_match = req_q.is_wr ? regs_wr_ack : regs_rd_ack;
  assign err_match = req_q.is_wr ? regs_wr_err : regs_rd_err;
  assign timeout   = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign cpl_err   = tmo_err | err_match;

  // An ack only counts once the request is past the stall; it beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    tmo_err   = 1'b0;
    case (state)
      IDLE: if (grant_valid) state_nxt = ISSUE;
      ISSUE: begin
        if (!stall && ack_match) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          complete  = 1'b1;
          tmo_err   = 1'b1;
          state_nxt = IDLE;
        end else if (!stall) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (ack_match) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          complete  = 1'b1;
          tmo_err   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      req_q      <= '0;
      tmo_cnt    <= '0;
      m_ack      <= '0;
      m_err      <= 1'b0;
      m_rd_data  <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= (state == IDLE) ? 16'd0 : tmo_cnt + 16'd1;
      if (grant) begin
        owner      <= grant_idx;
        last_grant <= grant_idx;
        req_q      <= req_sel;
      end
      m_ack     <= '0;
      m_err     <= 1'b0;
      m_rd_data <= '0;
      if (complete) begin
        m_ack[owner] <= 1'b1;
        m_err        <= cpl_err;
        m_rd_data    <= (req_q.is_wr || cpl_err) ? 32'd0 : regs_rd_data;
      end
    end
  end

  assign regs_req       = (state == ISSUE);
  assign regs_req_is_wr = req_q.is_wr;
  assign regs_addr      = req_q.addr;
  assign regs_wr_data   = req_q.wr_data;
  assign regs_wr_biten  = req_q.biten;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_hsv_core_ctrlstatus_cpuif_arbiter.sv
// Cycle-stepped bench: requesters and a regs responder are modelled at transaction level and every
// cycle's accept/ack/regs_req/busy is predicted from the arbitration and timeout rules.
module tb_hsv_core_ctrlstatus_cpuif_arbiter;
  localparam int N = 3;
  localparam int T = 8;

  logic            clk_core = 1'b0;
  logic            rst_core;
  logic            flush_req;
  logic [N-1:0]    m_req, m_req_is_wr, m_accept, m_ack;
  logic [N*16-1:0] m_addr;
  logic [N*32-1:0] m_wr_data, m_wr_biten;
  logic            m_err;
  logic [31:0]     m_rd_data;
  logic            regs_req, regs_req_is_wr;
  logic [15:0]     regs_addr;
  logic [31:0]     regs_wr_data, regs_wr_biten;
  logic            regs_req_stall_wr, regs_req_stall_rd;
  logic            regs_rd_ack, regs_rd_err, regs_wr_ack, regs_wr_err;
  logic [31:0]     regs_rd_data;
  logic            busy;

  always #5 clk_core = ~clk_core;

  hsv_core_ctrlstatus_cpuif_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req),
    .m_req(m_req), .m_req_is_wr(m_req_is_wr), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_wr_biten(m_wr_biten),
    .m_accept(m_accept), .m_ack(m_ack), .m_err(m_err), .m_rd_data(m_rd_data),
    .regs_req(regs_req), .regs_req_is_wr(regs_req_is_wr), .regs_addr(regs_addr),
    .regs_wr_data(regs_wr_data), .regs_wr_biten(regs_wr_biten),
    .regs_req_stall_wr(regs_req_stall_wr), .regs_req_stall_rd(regs_req_stall_rd),
    .regs_rd_ack(regs_rd_ack), .regs_rd_err(regs_rd_err),
    .regs_wr_ack(regs_wr_ack), .regs_wr_err(regs_wr_err),
    .regs_rd_data(regs_rd_data), .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // requester side
  logic [N-1:0] pend;
  logic [N-1:0] p_wr;
  logic [15:0]  p_addr [N];
  logic [31:0]  p_wd [N];
  logic [31:0]  p_be [N];
  logic [N-1:0] gen_mask;
  int           gen_pct;
  int           mlast;
  int           grants [$];

  // transaction in flight, as the bench expects it
  int          cyc;
  bit          tx_on, tx_wr, tx_err;
  int          tx_own, tx_e, tx_s, tx_ack_c, tx_done, tx_req_end;
  logic [80:0] tx_req;
  logic [31:0] tx_rdat, x_data;
  bit          x_err;
  int          rr_cnt;

  // responder knobs
  bit          noise, rnd_resp, stray_rd, flush_rand, k_na, k_err;
  int          k_s, k_d;
  logic [31:0] k_rd;

  task automatic post(input int i, input bit wr, input logic [15:0] a);
    pend[i] = 1'b1; p_wr[i] = wr; p_addr[i] = a; p_wd[i] = $urandom; p_be[i] = $urandom;
  endtask

  task automatic start_tx(input int g);
    int s, d, tmo; bit na, er; logic [31:0] rd;
    if (rnd_resp) begin
      s = int'($urandom_range(0, 4)); d = int'($urandom_range(0, 4));
      na = ($urandom_range(0, 9) == 0); er = ($urandom_range(0, 3) == 0); rd = $urandom;
    end else begin
      s = k_s; d = k_d; na = k_na; er = k_err; rd = k_rd;
    end
    tx_on = 1'b1; tx_own = g; tx_wr = p_wr[g];
    tx_req = {p_wr[g], p_addr[g], p_wd[g], p_be[g]};
    tx_e = cyc + 1; tx_s = s; tx_err = er; tx_rdat = rd;
    tmo = tx_e + T - 1;
    tx_req_end = (tx_e + s < tmo) ? tx_e + s : tmo;
    if (!na && tx_e + s + d <= tmo) begin
      tx_ack_c = tx_e + s + d; tx_done = tx_ack_c + 1;
      x_err = er; x_data = (!tx_wr && !er) ? rd : 32'd0;
    end else begin
      tx_ack_c = -1; tx_done = tmo + 1; x_err = 1'b1; x_data = 32'd0;
    end
  endtask

  task automatic step();
    logic [N-1:0] elig, exp_acc, exp_ack;
    int gi, j; bit idle, in_tx, in_req;
    for (int i = 0; i < N; i++)
      if (!pend[i] && gen_mask[i] && $urandom_range(0, 99) < gen_pct)
        post(i, ($urandom_range(0, 1) == 1), 16'($urandom));
    if (flush_rand && $urandom_range(0, 15) == 0) flush_req = ~flush_req;
    m_req = pend; m_req_is_wr = p_wr;
    for (int i = 0; i < N; i++) begin
      m_addr[i*16 +: 16] = p_addr[i]; m_wr_data[i*32 +: 32] = p_wd[i]; m_wr_biten[i*32 +: 32] = p_be[i];
    end
    regs_req_stall_wr = noise && ($urandom_range(0, 1) == 1);
    regs_req_stall_rd = noise && ($urandom_range(0, 1) == 1);
    regs_rd_err  = noise && ($urandom_range(0, 1) == 1);
    regs_wr_err  = noise && ($urandom_range(0, 1) == 1);
    regs_rd_data = noise ? $urandom : 32'd0;
    regs_rd_ack = 1'b0; regs_wr_ack = 1'b0;
    in_tx  = tx_on && cyc >= tx_e && cyc < tx_done;
    in_req = in_tx && cyc <= tx_req_end;
    if (in_tx) begin
      if (tx_wr) begin
        regs_req_stall_wr = (cyc < tx_e + tx_s);
        regs_wr_ack = (cyc == tx_ack_c);
        if (regs_wr_ack) regs_wr_err = tx_err;
        regs_rd_ack = noise && ($urandom_range(0, 1) == 1);
      end else begin
        regs_req_stall_rd = (cyc < tx_e + tx_s);
        regs_rd_ack = (cyc == tx_ack_c);
        if (regs_rd_ack) begin regs_rd_err = tx_err; regs_rd_data = tx_rdat; end
        regs_wr_ack = noise && ($urandom_range(0, 1) == 1);
      end
    end else begin
      regs_rd_ack = stray_rd || (noise && ($urandom_range(0, 1) == 1));
      regs_wr_ack = noise && ($urandom_range(0, 1) == 1);
    end
    #1;
    idle = !tx_on || cyc == tx_done;
    exp_ack = (tx_on && cyc == tx_done) ? (N'(1) << tx_own) : '0;
    check("m_ack", m_ack, exp_ack);
    if (exp_ack != '0) begin
      check("m_err", m_err, x_err);
      check("m_rd_data", m_rd_data, x_data);
      tx_on = 1'b0;
    end
    check("regs_req", regs_req, in_req);
    if (regs_req) rr_cnt++;
    if (in_req) check("regs_fields", {regs_req_is_wr, regs_addr, regs_wr_data, regs_wr_biten}, tx_req);
    check("busy", busy, in_tx);
    elig = pend;
    if (flush_req) elig[0] = 1'b0;
    gi = -1;
    if (idle)
      for (int k = N; k >= 1; k--) begin
        j = (mlast + k) % N;
        if (((elig >> j) & N'(1)) != '0) gi = j;
      end
    exp_acc = (gi >= 0) ? (N'(1) << gi) : '0;
    check("m_accept", m_accept, exp_acc);
    if (gi >= 0) begin
      start_tx(gi); pend[gi] = 1'b0; mlast = gi; grants.push_back(gi);
    end
    @(posedge clk_core); #1; cyc++;
  endtask

  function automatic logic [127:0] all_outs();
    return {m_accept, m_ack, m_err, m_rd_data, regs_req, regs_req_is_wr,
            regs_addr, regs_wr_data, regs_wr_biten, busy};
  endfunction

  initial begin
    rst_core = 1'b1; flush_req = 1'b0; pend = '0; p_wr = '0;
    for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_wd[i] = '0; p_be[i] = '0; end
    gen_mask = '0; gen_pct = 0; noise = 0; rnd_resp = 0; stray_rd = 0; flush_rand = 0;
    k_s = 0; k_d = 0; k_na = 0; k_err = 0; k_rd = '0;
    tx_on = 0; mlast = N - 1; cyc = 0; rr_cnt = 0;
    // reset with every requester and ack asserted: nothing may leak out
    m_req = '1; m_req_is_wr = '0; m_addr = '1; m_wr_data = '1; m_wr_biten = '1;
    regs_req_stall_wr = 0; regs_req_stall_rd = 0; regs_rd_ack = 1; regs_wr_ack = 1;
    regs_rd_err = 1; regs_wr_err = 1; regs_rd_data = '1;
    repeat (2) @(posedge clk_core);
    #1;
    check("reset_outputs", all_outs(), '0);
    rst_core = 1'b0;

    // single read, ack in the issue cycle
    post(1, 1'b0, 16'h0F14);
    repeat (4) step();

    // round robin with two continuous requesters
    grants.delete();
    gen_mask = 3'b011; gen_pct = 100; k_rd = 32'hA5A5_1234;
    repeat (12) step();
    gen_mask = '0;
    repeat (10) step();
    check("rr_order0", grants[0], 0);
    check("rr_order1", grants[1], 1);
    check("rr_order2", grants[2], 0);
    check("rr_order3", grants[3], 1);

    // stalled write that completes with an error
    post(1, 1'b1, 16'h0300); k_s = 5; k_d = 0; k_err = 1; rr_cnt = 0;
    repeat (9) step();
    check("stall_regs_req_cycles", rr_cnt, 6);

    // timeout, then a late read ack in IDLE, then a normal read
    post(0, 1'b0, 16'h0040); k_s = 0; k_na = 1; k_err = 0;
    repeat (T + 3) step();
    stray_rd = 1; repeat (2) step(); stray_rd = 0;
    k_na = 0; k_rd = 32'hDEAD_BEEF;
    post(1, 1'b0, 16'h0044);
    repeat (4) step();

    // flush while requester 0 is in flight
    post(0, 1'b1, 16'h0010); post(1, 1'b0, 16'h0014); k_d = 2;
    step();
    flush_req = 1'b1; gen_mask = 3'b011; gen_pct = 100; grants.delete();
    repeat (12) step();
    check("flush_n_grants", grants.size() > 1, 1'b1);
    foreach (grants[i]) check("flush_grant", grants[i], 1);
    flush_req = 1'b0; grants.delete();
    repeat (8) step();
    check("post_flush_req0", grants[0], 0);
    gen_mask = '0;
    repeat (10) step();

    // reset pulsed during WAIT
    post(0, 1'b0, 16'h0080); k_s = 0; k_d = 5;
    repeat (3) step();
    post(0, 1'b0, 16'h0084); post(1, 1'b1, 16'h0088);
    m_req = pend;
    rst_core = 1'b1;
    #1;
    check("reset_mid_wait_outputs", all_outs(), '0);
    @(posedge clk_core); #1;
    rst_core = 1'b0; tx_on = 0; mlast = N - 1; grants.delete(); k_d = 0; cyc++;
    repeat (8) step();
    check("after_reset_first_grant", grants[0], 0);

    // randomized traffic with stray acks, noise stalls and flush toggling
    noise = 1; rnd_resp = 1; gen_mask = '1; gen_pct = 30; flush_rand = 1;
    repeat (3000) step();
    noise = 0; flush_rand = 0; flush_req = 1'b0; gen_mask = '0;
    repeat (30) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
